// File: rtl/csa_pkg.sv
// Shared helpers for the carry-save adder.
// These compute tree depth and per-level operand counts at elaboration time.
package csa_pkg;

    localparam int unsigned DefaultW    = 3;
    localparam int unsigned DefaultE    = 5;
    localparam int unsigned ResultWidth = DefaultW + DefaultE + 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r = 0;
        int unsigned v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned result_width(input int unsigned w, input int unsigned e);
        return w + e + 1;
    endfunction

    // Operands remaining after one 3:2 level; leftovers pass through untouched.
    function automatic int unsigned next_count(input int unsigned n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int unsigned count_at_level(input int unsigned n, input int unsigned lvl);
        int unsigned c = n;
        for (int unsigned i = 0; i < lvl; i++) begin
            c = next_count(c);
        end
        return c;
    endfunction

    function automatic int unsigned num_levels(input int unsigned n);
        int unsigned c = n;
        int unsigned l = 0;
        while (c > 2) begin
            c = next_count(c);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// One row of full adders: compresses three vectors into a sum and an unshifted carry vector.
module csa_3to2
    import csa_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [Width-1:0] c_i,
    output logic [Width-1:0] sum_o,
    output logic [Width-1:0] carry_o
);

    always_comb begin
        sum_o   = a_i ^ b_i ^ c_i;
        carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// File: rtl/carry_save_adder.sv
// Registered multi-operand unsigned adder: 3:2 compressor tree followed by one CPA.
// Define CSA_PIPE_EN to register the tree outputs before the CPA (latency 2 instead of 1).
module carry_save_adder
    import csa_pkg::*;
#(
    parameter int unsigned N = 49,
    parameter int unsigned E = 5,
    parameter int unsigned W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W*N-1:0]   a,
    output logic [W+E-1:0]   sum,
    output logic             cout
);

    localparam int unsigned RW        = result_width(W, E);
    localparam int unsigned NumLevels = num_levels(N);

    if (N < 3) begin : g_n_check
        $error("carry_save_adder: N must be at least 3");
    end
    if (RW < W + clog2(N)) begin : g_width_check
        $error("carry_save_adder: W+E+1 is too narrow to hold the sum of N operands");
    end

    // lvl[l][k] is operand k entering tree level l; slots past the live count are tied to 0.
    logic [RW-1:0] lvl [NumLevels+1][N];

    for (genvar k = 0; k < N; k++) begin : g_ext
        assign lvl[0][k] = {{(RW - W){1'b0}}, a[k*W +: W]};
    end

    for (genvar l = 0; l < NumLevels; l++) begin : g_lvl
        localparam int unsigned Cnt = count_at_level(N, l);
        localparam int unsigned Grp = Cnt / 3;
        localparam int unsigned Rem = Cnt % 3;
        localparam int unsigned Nxt = 2 * Grp + Rem;

        for (genvar g = 0; g < Grp; g++) begin : g_grp
            logic [RW-1:0] x0, x1, x2;
            logic [RW-2:0] s_lo, c_lo;

            assign x0 = lvl[l][3*g];
            assign x1 = lvl[l][3*g+1];
            assign x2 = lvl[l][3*g+2];

            // The carry out of the top column lands beyond the result width, so only the
            // low RW-1 columns need a full adder carry; the top column keeps just its sum bit.
            csa_3to2 #(
                .Width (RW - 1)
            ) u_fa (
                .a_i     (x0[RW-2:0]),
                .b_i     (x1[RW-2:0]),
                .c_i     (x2[RW-2:0]),
                .sum_o   (s_lo),
                .carry_o (c_lo)
            );

            assign lvl[l+1][2*g]   = {x0[RW-1] ^ x1[RW-1] ^ x2[RW-1], s_lo};
            assign lvl[l+1][2*g+1] = {c_lo, 1'b0};
        end

        for (genvar r = 0; r < Rem; r++) begin : g_pass
            assign lvl[l+1][2*Grp+r] = lvl[l][3*Grp+r];
        end

        for (genvar k = Nxt; k < N; k++) begin : g_pad
            assign lvl[l+1][k] = '0;
        end
    end

    logic [RW-1:0] s_tree, c_tree;
    logic [RW-1:0] s_cpa, c_cpa;

    assign s_tree = lvl[NumLevels][0];
    assign c_tree = lvl[NumLevels][1];

`ifdef CSA_PIPE_EN
    logic [RW-1:0] s_d, s_q, c_d, c_q;

    always_comb begin
        s_d = s_tree;
        c_d = c_tree;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= '0;
            c_q <= '0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    assign s_cpa = s_q;
    assign c_cpa = c_q;
`else
    assign s_cpa = s_tree;
    assign c_cpa = c_tree;
`endif

    logic [RW-1:0] total_d, total_q;

    always_comb begin
        total_d = s_cpa + c_cpa;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign sum  = total_q[RW-2:0];
    assign cout = total_q[RW-1];

endmodule

// File: tb/tb_carry_save_adder.sv
// Directed and LFSR-driven checks of carry_save_adder at N=49, W=3, E=5.
module tb_carry_save_adder;

    localparam int unsigned N  = 49;
    localparam int unsigned W  = 3;
    localparam int unsigned E  = 5;
    localparam int unsigned NW = W * N;
`ifdef CSA_PIPE_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic            clk;
    logic            rst_n;
    logic [NW-1:0]   a;
    logic [W+E-1:0]  sum;
    logic            cout;
    logic [W+E:0]    total;

    int n_tests = 0;
    int n_fail  = 0;

    carry_save_adder #(
        .N (N),
        .E (E),
        .W (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .sum   (sum),
        .cout  (cout)
    );

    assign total = {cout, sum};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NW-1:0] one_op(input int k, input int v);
        logic [NW-1:0] r;
        r = '0;
        r[k*W +: W] = v[W-1:0];
        return r;
    endfunction

    function automatic int operand_sum(input logic [NW-1:0] v);
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(v[k*W +: W]);
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a     = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (total !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %0d, want 0", i, total);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < Lat; i++) tick();
        n_tests++;
        if (cout !== 1'b1 || sum !== 8'd87) begin
            n_fail++;
            $display("FAIL reset_release: got cout=%0d sum=%0d, want cout=1 sum=87", cout, sum);
        end
    endtask

    task automatic test_zero_and_single();
        a = '0;
        for (int i = 0; i < Lat; i++) tick();
        n_tests++;
        if (total !== 9'd0) begin
            n_fail++;
            $display("FAIL all_zero: got %0d, want 0", total);
        end
        a = one_op(0, 5);
        for (int i = 0; i < Lat; i++) tick();
        n_tests++;
        if (total !== 9'd5) begin
            n_fail++;
            $display("FAIL single_op0: got %0d, want 5", total);
        end
        a = one_op(48, 6);
        for (int i = 0; i < Lat; i++) tick();
        n_tests++;
        if (total !== 9'd6) begin
            n_fail++;
            $display("FAIL single_op48: got %0d, want 6", total);
        end
    endtask

    task automatic test_alternating();
        a = '0;
        for (int k = 0; k < N; k += 2) a = a | one_op(k, 7);
        for (int i = 0; i < Lat; i++) tick();
        n_tests++;
        if (cout !== 1'b0 || sum !== 8'd175) begin
            n_fail++;
            $display("FAIL alternating: got cout=%0d sum=%0d, want cout=0 sum=175", cout, sum);
        end
    endtask

    task automatic test_back_to_back();
        logic [NW-1:0] vec [3];
        int            exp [3];
        vec[0] = '1;
        vec[1] = '0;
        vec[2] = one_op(0, 1);
        exp[0] = 343;
        exp[1] = 0;
        exp[2] = 1;
        for (int i = 0; i < 3 + Lat - 1; i++) begin
            if (i < 3) a = vec[i];
            tick();
            if (i >= Lat - 1) begin
                n_tests++;
                if (total !== exp[i-Lat+1][W+E:0]) begin
                    n_fail++;
                    $display("FAIL back_to_back[%0d]: got %0d, want %0d",
                             i - Lat + 1, total, exp[i-Lat+1]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        a = '1;
        for (int i = 0; i < Lat + 1; i++) tick();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (total !== 9'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %0d, want 0", total);
        end
        rst_n = 1'b1;
        a     = one_op(3, 5);
        tick();
        // With the pipe stage the first post-reset result is the flushed (zero) tree state.
        n_tests++;
        if (total !== ((Lat == 1) ? 9'd5 : 9'd0)) begin
            n_fail++;
            $display("FAIL mid_reset_flush: got %0d, want %0d", total, (Lat == 1) ? 5 : 0);
        end
        for (int i = 1; i < Lat; i++) tick();
        n_tests++;
        if (total !== 9'd5) begin
            n_fail++;
            $display("FAIL mid_reset_resume: got %0d, want 5", total);
        end
    endtask

    task automatic test_random();
        int q[$];
        int exp;
        int bad = 0;
        a = '1;
        for (int i = 0; i < 3000; i++) begin
            q.push_back(operand_sum(a));
            tick();
            if (q.size() == Lat) begin
                exp = q.pop_front();
                n_tests++;
                if (total !== exp[W+E:0]) begin
                    n_fail++;
                    bad++;
                    if (bad <= 5) $display("FAIL random[%0d]: got %0d, want %0d", i, total, exp);
                end
            end
            a = {a[NW-2:0], a[NW-1] ^ a[NW-2]};
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a     = '0;
        test_reset();
        test_zero_and_single();
        test_alternating();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
